// File: rtl/sr_imem_arbiter.sv
// Round-robin arbiter sharing one single-port instruction memory between an
// I-cache refill port (BURST-word reads) and a loader/debug port (single word).
module sr_imem_arbiter #(
  parameter  int AW    = 16,
  parameter  int BURST = 4,
  localparam int BW    = $clog2(BURST)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  output logic [31:0]   p0_rdata,
  output logic          p0_rvalid,
  output logic [BW-1:0] p0_idx,
  output logic          p0_done,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic [31:0]   p1_rdata,
  output logic          p1_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_SINGLE, S_RELEASE} state_e;

  localparam logic [AW-1:0] LOW_MASK  = AW'(BURST - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic [31:0]   p0_rdata_q, p0_rdata_d;
  logic          p0_rvalid_q, p0_rvalid_d;
  logic [BW-1:0] p0_idx_q, p0_idx_d;
  logic          p0_done_q, p0_done_d;
  logic [31:0]   p1_rdata_q, p1_rdata_d;
  logic          p1_ack_q, p1_ack_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]    grant_q, grant_d;

  logic          pick0, pick1, acked;
  logic [BW-1:0] cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      base_q      <= '0;
      p0_rdata_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p0_idx_q    <= '0;
      p0_done_q   <= 1'b0;
      p1_rdata_q  <= '0;
      p1_ack_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      p0_rdata_q  <= p0_rdata_d;
      p0_rvalid_q <= p0_rvalid_d;
      p0_idx_q    <= p0_idx_d;
      p0_done_q   <= p0_done_d;
      p1_rdata_q  <= p1_rdata_d;
      p1_ack_q    <= p1_ack_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      grant_q     <= grant_d;
    end
  end

  // last_q names the port served most recently; a tie goes to the other one.
  assign pick0   = p0_req & (~p1_req | last_q);
  assign pick1   = p1_req & ~pick0;
  assign acked   = mem_ack & mem_req_q;
  assign cnt_nxt = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    p0_rdata_d  = p0_rdata_q;
    p0_rvalid_d = 1'b0;
    p0_idx_d    = p0_idx_q;
    p0_done_d   = 1'b0;
    p1_rdata_d  = p1_rdata_q;
    p1_ack_d    = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_d     = grant_q;
    case (state_q)
      S_IDLE: begin
        if (pick0) begin
          state_d    = S_BURST;
          last_d     = 1'b0;
          cnt_d      = '0;
          base_d     = p0_addr & ~LOW_MASK;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = p0_addr & ~LOW_MASK;
          grant_d    = 2'b01;
        end else if (pick1) begin
          state_d     = S_SINGLE;
          last_d      = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = p1_we;
          mem_addr_d  = p1_addr;
          mem_wdata_d = p1_wdata;
          grant_d     = 2'b10;
        end
      end
      S_BURST: begin
        if (acked) begin
          p0_rdata_d  = mem_rdata;
          p0_rvalid_d = 1'b1;
          p0_idx_d    = cnt_q;
          if (cnt_q == LAST_BEAT) begin
            state_d   = S_RELEASE;
            cnt_d     = '0;
            p0_done_d = 1'b1;
            mem_req_d = 1'b0;
            grant_d   = 2'b00;
          end else begin
            // Aligned base has zero low bits, so OR-ing the beat index never carries.
            cnt_d      = cnt_nxt;
            mem_addr_d = base_q | AW'(cnt_nxt);
          end
        end
      end
      S_SINGLE: begin
        if (acked) begin
          state_d   = S_RELEASE;
          p1_ack_d  = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          grant_d   = 2'b00;
          if (!mem_we_q) p1_rdata_d = mem_rdata;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign p0_rdata  = p0_rdata_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p0_idx    = p0_idx_q;
  assign p0_done   = p0_done_q;
  assign p1_rdata  = p1_rdata_q;
  assign p1_ack    = p1_ack_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_sr_imem_arbiter.sv
// Directed bench for sr_imem_arbiter: a cycle table for the zero-wait refill
// plus hand sequences for wait states, loader, fairness, spurious ack and reset.
module tb_sr_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req;
  logic [15:0] p0_addr;
  logic [31:0] p0_rdata;
  logic        p0_rvalid;
  logic [1:0]  p0_idx;
  logic        p0_done;
  logic        p1_req;
  logic        p1_we;
  logic [15:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [31:0] p1_rdata;
  logic        p1_ack;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  grant;

  logic        ack_all, ack_div3;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  // One-entry write store; unwritten words read back as addr + 0xA000.
  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr  = 16'h0;
  logic [31:0] wr_data  = 32'h0;

  sr_imem_arbiter #(.AW(16), .BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_rdata(p0_rdata),
    .p0_rvalid(p0_rvalid), .p0_idx(p0_idx), .p0_done(p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant(grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && mem_ack && mem_we) begin
      wr_valid <= 1'b1;
      wr_addr  <= mem_addr;
      wr_data  <= mem_wdata;
    end
  end

  assign mem_ack   = ack_all | (ack_div3 & (cyc % 3 == 0));
  assign mem_rdata = (wr_valid && wr_addr == mem_addr) ? wr_data : (32'hA000 + {16'h0, mem_addr});

  logic any_out;
  assign any_out = |{p0_rdata, p0_rvalid, p0_idx, p0_done, p1_rdata, p1_ack,
                     mem_req, mem_we, mem_addr, mem_wdata, grant};

  typedef struct {
    logic        p0_req;
    logic [15:0] p0_addr;
    logic        e_req;
    logic [15:0] e_addr;
    logic [1:0]  e_grant;
    logic        e_rv;
    logic [1:0]  e_idx;
    logic        e_done;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    p0_req = 0; p1_req = 0; ack_all = 0; ack_div3 = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    int nrv, ndone, nack, hold_bad, bad;
    logic done_seen, prev_req, prev_ack;
    logic [15:0] prev_addr;
    logic [1:0] prev_g;
    logic [1:0] starts [$];
    logic [63:0] got, exp;

    // Zero-wait refill from 0x0013: block 0x0010..0x0013.
    tbl[0] = '{1'b1, 16'h0013, 1'b1, 16'h0010, 2'b01, 1'b0, 2'd0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 16'h0013, 1'b1, 16'h0011, 2'b01, 1'b1, 2'd0, 1'b0, 32'hA010};
    tbl[2] = '{1'b1, 16'h0013, 1'b1, 16'h0012, 2'b01, 1'b1, 2'd1, 1'b0, 32'hA011};
    tbl[3] = '{1'b1, 16'h0013, 1'b1, 16'h0013, 2'b01, 1'b1, 2'd2, 1'b0, 32'hA012};
    tbl[4] = '{1'b1, 16'h0013, 1'b0, 16'h0000, 2'b00, 1'b1, 2'd3, 1'b1, 32'hA013};
    tbl[5] = '{1'b0, 16'h0013, 1'b0, 16'h0000, 2'b00, 1'b0, 2'd0, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 16'h0013, 1'b0, 16'h0000, 2'b00, 1'b0, 2'd0, 1'b0, 32'h0};

    rst_n = 0; p0_req = 0; p0_addr = 0; p1_req = 0; p1_we = 0; p1_addr = 0;
    p1_wdata = 0; ack_all = 0; ack_div3 = 0;
    tick(); tick();
    check("reset outputs", {63'h0, any_out}, 64'h0);
    rst_n = 1;

    // Table: zero-wait refill, ack tied high (also high while idle).
    ack_all = 1;
    for (int i = 0; i < 7; i++) begin
      p0_req  = tbl[i].p0_req;
      p0_addr = tbl[i].p0_addr;
      tick();
      got = {9'h0, mem_req, tbl[i].e_req ? mem_addr : 16'h0, grant, p0_rvalid,
             tbl[i].e_rv ? p0_idx : 2'd0, p0_done, tbl[i].e_rv ? p0_rdata : 32'h0};
      exp = {9'h0, tbl[i].e_req, tbl[i].e_req ? tbl[i].e_addr : 16'h0, tbl[i].e_grant,
             tbl[i].e_rv, tbl[i].e_rv ? tbl[i].e_idx : 2'd0, tbl[i].e_done,
             tbl[i].e_rv ? tbl[i].e_rdata : 32'h0};
      check($sformatf("zero-wait row %0d", i), got, exp);
    end

    // Wait-state refill: ack every third cycle.
    ack_all = 0; ack_div3 = 1;
    p0_req = 1; p0_addr = 16'h0010;
    nrv = 0; hold_bad = 0; done_seen = 0; prev_req = 0; prev_ack = 0; prev_addr = 0;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      tick();
      if (prev_req && mem_req && !prev_ack && mem_addr !== prev_addr) hold_bad++;
      if (p0_rvalid) begin
        check($sformatf("wait beat %0d data", nrv), {32'h0, p0_rdata}, 64'hA010 + 64'(nrv));
        check($sformatf("wait beat %0d idx", nrv), {62'h0, p0_idx}, 64'(nrv));
        nrv++;
      end
      if (p0_done) begin done_seen = 1; p0_req = 0; end
      prev_req = mem_req; prev_addr = mem_addr; prev_ack = mem_ack;
    end
    check("wait done seen", {63'h0, done_seen}, 64'h1);
    check("wait rvalid count", 64'(nrv), 64'd4);
    check("wait addr hold", 64'(hold_bad), 64'd0);
    ack_div3 = 0;
    tick(); tick();

    // Loader write then read back.
    ack_all = 1;
    p1_req = 1; p1_we = 1; p1_addr = 16'h0100; p1_wdata = 32'hDEADBEEF;
    tick();
    check("write issue", {44'h0, mem_req, mem_we, grant, mem_addr}, {44'h0, 1'b1, 1'b1, 2'b10, 16'h0100});
    check("write wdata", {32'h0, mem_wdata}, 64'hDEADBEEF);
    nack = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (p1_ack) begin nack++; p1_req = 0; end
    end
    check("write ack count", 64'(nack), 64'd1);
    p1_req = 1; p1_we = 0;
    tick();
    check("read issue", {44'h0, mem_req, mem_we, grant, mem_addr}, {44'h0, 1'b1, 1'b0, 2'b10, 16'h0100});
    tick();
    check("read ack", {31'h0, p1_ack, p1_rdata}, {31'h0, 1'b1, 32'hDEADBEEF});
    p1_req = 0;
    tick(); tick();

    // Fairness: both ports held high after reset.
    do_reset();
    ack_all = 1;
    p0_req = 1; p0_addr = 16'h0020; p1_req = 1; p1_we = 0; p1_addr = 16'h0100;
    prev_g = 0; bad = 0;
    for (int c = 0; c < 40 && starts.size() < 4; c++) begin
      tick();
      if (grant == 2'b11) bad++;
      if (grant != 2'b00 && prev_g == 2'b00) starts.push_back(grant);
      prev_g = grant;
    end
    check("fair start count", 64'(starts.size()), 64'd4);
    check("fair onehot", 64'(bad), 64'd0);
    for (int i = 0; i < starts.size(); i++)
      check($sformatf("fair grant %0d", i), {62'h0, starts[i]}, (i % 2 == 0) ? 64'h1 : 64'h2);
    p0_req = 0; p1_req = 0;

    // Spurious ack in idle, then early p0_req drop.
    do_reset();
    ack_all = 1; bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mem_req | p0_rvalid | p0_done | p1_ack | (grant != 0)) bad++;
    end
    check("spurious ack idle", 64'(bad), 64'd0);
    p0_req = 1; p0_addr = 16'h0020;
    nrv = 0; ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (p0_rvalid) nrv++;
      if (p0_done) ndone++;
      if (nrv == 2) p0_req = 0;
    end
    check("early drop beats", 64'(nrv), 64'd4);
    check("early drop done", 64'(ndone), 64'd1);

    // Reset mid-burst after two beats.
    do_reset();
    ack_all = 1;
    p0_req = 1; p0_addr = 16'h0040;
    tick(); tick(); tick();
    rst_n = 0;
    #1;
    check("mid-burst reset outputs", {63'h0, any_out}, 64'h0);
    p0_req = 0;
    tick();
    rst_n = 1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (mem_req | p0_done | p0_rvalid) bad++;
    end
    check("post-reset quiet", 64'(bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sr_imem_arbiter.md
Name: sr_imem_arbiter

Overview:
- Shares one single-port backing instruction memory between two requesters.
  - Port 0: I-cache line refill, read-only, BURST words per request.
  - Port 1: loader/debug, single-word read or write.
- Sits between the I-cache/loader and the memory model.
- Sequences one memory access at a time and arbitrates round-robin between the two ports.
- A granted transaction always runs to completion without pre-emption.

Parameters:
AW, 16, word-address width of all address ports
BURST, 4, words per port-0 refill (power of 2, >=2); BW = log2(BURST)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
p0_req  in  1  refill request, level, held until p0_done
p0_addr  in  AW  refill word address; low BW bits ignored (forced 0)
p0_rdata  out  32  refill data beat
p0_rvalid  out  1  p0_rdata valid, one-cycle pulse per beat
p0_idx  out  BW  beat index of p0_rdata
p0_done  out  1  last beat, coincident with final p0_rvalid
p1_req  in  1  loader request, level, held until p1_ack
p1_we  in  1  1 = write, 0 = read
p1_addr  in  AW  loader word address
p1_wdata  in  32  write data
p1_rdata  out  32  read data, valid with p1_ack
p1_ack  out  1  one-cycle completion pulse
mem_req  out  1  memory access request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid with mem_ack
mem_ack  in  1  access complete; meaningful only while mem_req=1
grant  out  2  one-hot owner: bit0 = port 0, bit1 = port 1

Behaviour:
- Reset, async, rst_n=0:
  - state=IDLE, last=1 (port 0 wins first tie), beat counter=0.
  - All outputs 0.
  - Any in-flight memory access is abandoned; no completion pulse is produced for it.
- Registered outputs: all outputs are registers; there is no combinational path from inputs to outputs.
- State machine: IDLE, BURST, SINGLE, RELEASE.
- IDLE:
  - Only p0_req: enter BURST; latch base = {p0_addr[AW-1:BW], BW'b0}.
  - Only p1_req: enter SINGLE; latch p1_we, p1_addr, p1_wdata.
  - Both: grant the port != last.
  - Next cycle, mem_req=1 and grant is set.
  - Update last to the granted port.
- BURST:
  - mem_we=0, mem_addr=base+cnt.
  - On mem_ack:
    - Capture mem_rdata to p0_rdata.
    - Next cycle p0_rvalid=1, p0_idx=cnt.
    - cnt increments.
    - If cnt != BURST-1, mem_req stays 1 with the new address (back-to-back; each ack cycle completes exactly one access).
  - Final beat (cnt=BURST-1 acked):
    - Next cycle mem_req=0, p0_done=1 with p0_rvalid.
    - Go to RELEASE, cnt=0.
  - Dropping p0_req mid-burst does not abort; the burst completes and p0_done still pulses.
- SINGLE:
  - mem_req=1, mem_we/addr/wdata come from the latched values.
  - On mem_ack: next cycle mem_req=0, p1_ack=1, and p1_rdata=mem_rdata (reads only; write leaves p1_rdata unchanged). Go to RELEASE.
- RELEASE:
  - One cycle; grant=0, no arbitration. Go to IDLE.
  - Gives the requester one cycle to drop req after done/ack.
  - A req still high in IDLE is treated as a new request.
- Addressing: base+cnt never carries out of the aligned block (cnt < BURST). mem_addr wraps mod 2^AW only via the base itself.
- mem_ack while mem_req=0 is ignored.
- Latency, zero-wait memory (mem_ack tied high):
  - p0_req seen in IDLE at cycle 0.
  - mem_req at cycles 1..BURST; p0_rvalid at 2..BURST+1.
  - p0_done at BURST+1; earliest next mem_req at BURST+3.
- Fairness: while both ports hold req continuously, grants alternate strictly.

Test Plan:
- Reset: assert rst_n=0 mid-burst (after 2 beats) -> all outputs 0 the same cycle. After release with no req -> mem_req stays 0 and no p0_done appears.
- Zero-wait refill: p0_addr=0x0013, ack tied high -> mem_addr 0x0010,0x0011,0x0012,0x0013 on cycles 1-4. Returned data appears with p0_idx 0-3 on cycles 2-5; p0_done on cycle 5 only.
- Wait-state refill: mem_ack asserted every 3rd cycle, memory returns addr+0xA000 -> p0_rdata 0xA010..0xA013 in order. mem_addr holds until each ack; exactly 4 p0_rvalid pulses.
- Loader write then read: p1_we=1, addr=0x0100, wdata=0xDEADBEEF -> mem_we=1 and p1_ack once. Then read 0x0100 -> mem_we=0 and p1_rdata=0xDEADBEEF with p1_ack.
- Simultaneous requests after reset: p0_req and p1_req both held -> grant order port0, port1, port0, port1. A RELEASE cycle (grant=0) separates each transaction.
- Spurious ack and early drop: mem_ack=1 in IDLE -> no pulses. p0_req dropped after beat 1 -> remaining beats still issued, p0_done still pulses.
